seq_mult32: RTL

- Iterative unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
- Retires one multiplier bit per clock through a (WIDTH+1)-bit add/shift datapath.
- Sits downstream of the 32-bit adder in the lab datapath and reuses the same addition each cycle.
- Start/busy/done handshake to the controlling FSM or testbench.

---
 rtl/seq_mult32.sv | 91 +++++++++
 1 files changed

// File: rtl/seq_mult32.sv
// seq_mult32: iterative unsigned shift-and-add multiplier.
// Retires one multiplier bit per clock through a (WIDTH+1)-bit add/shift
// datapath; start/busy/done handshake; result held until the next start.
module seq_mult32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      mq;
  logic [WIDTH:0]        acc;
  logic [WIDTH:0]        sum;
  logic [2*WIDTH-1:0]    shifted;
  logic [CNT_W-1:0]      cnt;
  logic                  last;
  logic                  accept;

  // Partial-product add and the combined right-shifted {sum, mq} view.
  // acc[WIDTH] is always 0 after a shift, so adding the full acc is the
  // same as zero-extending its low WIDTH bits.
  always_comb begin
    sum     = acc + (mq[0] ? {1'b0, mcand} : '0);
    shifted = {sum, mq[WIDTH-1:1]};
    last    = (cnt == LAST_CNT);
    accept  = start && (state != RUN);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start accepted in IDLE or DONE, ignored in RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture, add/shift iterations and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mq      <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      mcand <= a;
      mq    <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      {acc, mq} <= {1'b0, sum, mq[WIDTH-1:1]};
      cnt       <= cnt + 1'b1;
      if (last) begin
        product <= shifted;
        ovf     <= |shifted[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule
